// File: rtl/vga_timing_pkg.sv
// Shared definitions for the raster timing generator.
//   - 640x480@60 default timing constants (pixel/line counts, polarities)
//   - raster state encoding (IDLE / ACTIVE / STOPPING)
//   - helper deriving line/frame totals from the four region widths
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_H_POL     = 0;
  localparam int DEF_V_POL     = 0;
  localparam int DEF_CNT_W     = 11;
  localparam int DEF_CLK_DIV   = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_STOPPING = 2'd2
  } raster_state_t;

  // Total positions per line (or lines per frame) from the region widths.
  function automatic int calc_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-strobe divider.
//   Counts 0..CLK_DIV-1 continuously; tick is high on the last count, so
//   one tick occurs every CLK_DIV clocks. With CLK_DIV=1 tick is always high.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset (counter returns to 0)
//   tick  - high on the final clk cycle of each pixel period
module vga_pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
//   Walks (x,y) over the full porch-inclusive raster at one position per
//   pixel tick, producing sync, visible-area enable and strobe pulses.
//   Stopping is frame-aligned: dropping run lets the current frame finish.
// Ports:
//   clk         - system clock (pixel rate = clk / CLK_DIV)
//   reset       - asynchronous active-high reset
//   run         - level-sensitive raster enable, sampled on pixel ticks
//   x, y        - current raster position
//   hsync/vsync - syncs, active level set by H_POL / V_POL
//   en          - high while the presented position is in the visible area
//   pix_stb     - one-clk pulse on the first cycle of each new position
//   line_start  - pix_stb at x==0
//   frame_start - pix_stb at x==0, y==0
//   frame_cnt   - completed-frame counter (only with VGA_TIMING_FRAME_CNT_EN)
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int H_POL     = DEF_H_POL,
  parameter int V_POL     = DEF_V_POL,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             en,
  output logic             pix_stb,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOTAL = calc_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calc_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  logic tick;

  vga_pix_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_div (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  raster_state_t    state;
  raster_state_t    state_nxt;
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             stb_nxt;
  logic             live_nxt;
  logic             hs_act_nxt;
  logic             vs_act_nxt;
  logic             en_nxt;
  logic             line_nxt;
  logic             frame_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next position. Between ticks everything holds, so the
  // output registers below reload identical values and only move on ticks.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    stb_nxt   = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state_nxt = ST_ACTIVE;
            x_nxt     = '0;
            y_nxt     = '0;
            stb_nxt   = 1'b1;
          end
        end
        ST_ACTIVE, ST_STOPPING: begin
          if ((state == ST_STOPPING) && !run && (x == H_LAST) && (y == V_LAST)) begin
            state_nxt = ST_IDLE;
            x_nxt     = '0;
            y_nxt     = '0;
          end else begin
            state_nxt = run ? ST_ACTIVE : ST_STOPPING;
            stb_nxt   = 1'b1;
            if (x == H_LAST) begin
              x_nxt = '0;
              y_nxt = (y == V_LAST) ? '0 : y + 1'b1;
            end else begin
              x_nxt = x + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          x_nxt     = '0;
          y_nxt     = '0;
        end
      endcase
    end
  end

  // All decoded outputs come from the same next position so they never skew.
  always_comb begin
    live_nxt   = (state_nxt != ST_IDLE);
    hs_act_nxt = live_nxt && (x_nxt >= HS_START) && (x_nxt < HS_END);
    vs_act_nxt = live_nxt && (y_nxt >= VS_START) && (y_nxt < VS_END);
    en_nxt     = live_nxt && (x_nxt < H_VIS) && (y_nxt < V_VIS);
    line_nxt   = stb_nxt && (x_nxt == '0);
    frame_nxt  = line_nxt && (y_nxt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      en          <= 1'b0;
      pix_stb     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= x_nxt;
      y           <= y_nxt;
      hsync       <= hs_act_nxt ? HS_ON : ~HS_ON;
      vsync       <= vs_act_nxt ? VS_ON : ~VS_ON;
      en          <= en_nxt;
      pix_stb     <= stb_nxt;
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // The frame_start that leaves IDLE opens a frame rather than closing one,
  // so only wraps to (0,0) from a running state are counted.
  logic count_frame;

  assign count_frame = frame_nxt && (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (count_frame) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small raster CLK_DIV=1,
// small raster CLK_DIV=3 with positive syncs and random run, default
// 640x480 raster CLK_DIV=4) each compared every cycle against a model
// that tracks a linear position index within the frame.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    int hpol; int vpol; int div;
  } cfg_t;

  typedef struct packed {
    int d;
    int p;
    int fcnt;
    bit idle;
    bit stopping;
    bit stb;
  } mdl_t;

  localparam cfg_t CFG_A = '{hv:4, hf:1, hs:2, hb:1, vv:3, vf:1, vs:1, vb:1,
                             hpol:0, vpol:0, div:1};
  localparam cfg_t CFG_B = '{hv:4, hf:1, hs:2, hb:1, vv:3, vf:1, vs:1, vb:1,
                             hpol:1, vpol:1, div:3};
  localparam cfg_t CFG_C = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33,
                             hpol:0, vpol:0, div:4};
  localparam mdl_t MRST  = '{d:0, p:0, fcnt:0, idle:1'b1, stopping:1'b0, stb:1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_a = 1'b1;
  logic run_b = 1'b0;
  logic run_c = 1'b1;
  logic done = 1'b0;

  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic hs_a, vs_a, en_a, stb_a, ls_a, fs_a;
  logic hs_b, vs_b, en_b, stb_b, ls_b, fs_b;
  logic hs_c, vs_c, en_c, stb_c, ls_c, fs_c;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b, fc_c;
`endif

  int n_vec = 0;
  int n_err = 0;

  mdl_t ma = MRST;
  mdl_t mb = MRST;
  mdl_t mc = MRST;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(0), .V_POL(0), .CNT_W(11), .CLK_DIV(1)
  ) dut_a (
    .clk(clk), .reset(rst), .run(run_a), .x(x_a), .y(y_a),
    .hsync(hs_a), .vsync(vs_a), .en(en_a), .pix_stb(stb_a),
    .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1), .V_POL(1), .CNT_W(11), .CLK_DIV(3)
  ) dut_b (
    .clk(clk), .reset(rst), .run(run_b), .x(x_b), .y(y_b),
    .hsync(hs_b), .vsync(vs_b), .en(en_b), .pix_stb(stb_b),
    .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(4)
  ) dut_c (
    .clk(clk), .reset(rst), .run(run_c), .x(x_c), .y(y_c),
    .hsync(hs_c), .vsync(vs_c), .en(en_c), .pix_stb(stb_c),
    .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_c)
`endif
  );

  // One clock edge of the reference: p is the linear index within the frame.
  function automatic mdl_t step(input cfg_t c, input mdl_t m, input bit run);
    int  tot;
    bit  tick;
    tot  = (c.hv + c.hf + c.hs + c.hb) * (c.vv + c.vf + c.vs + c.vb);
    tick = (m.d == c.div - 1);
    m.d  = (m.d + 1) % c.div;
    m.stb = 1'b0;
    if (tick) begin
      if (m.idle) begin
        if (run) begin
          m.idle = 1'b0; m.p = 0; m.stb = 1'b1; m.stopping = 1'b0;
        end
      end else if (m.stopping && !run && m.p == tot - 1) begin
        m.idle = 1'b1; m.p = 0;
      end else begin
        m.p = (m.p + 1) % tot;
        m.stopping = !run;
        m.stb = 1'b1;
        if (m.p == 0) m.fcnt = (m.fcnt + 1) % 65536;
      end
    end
    return m;
  endfunction

  function automatic logic [27:0] expect_out(input cfg_t c, input mdl_t m);
    int   ht, xi, yi;
    logic hs, vs, en, ls, fs;
    ht = c.hv + c.hf + c.hs + c.hb;
    xi = m.idle ? 0 : m.p % ht;
    yi = m.idle ? 0 : m.p / ht;
    hs = (!m.idle && xi >= c.hv + c.hf && xi < c.hv + c.hf + c.hs) ? (c.hpol != 0) : (c.hpol == 0);
    vs = (!m.idle && yi >= c.vv + c.vf && yi < c.vv + c.vf + c.vs) ? (c.vpol != 0) : (c.vpol == 0);
    en = !m.idle && xi < c.hv && yi < c.vv;
    ls = m.stb && xi == 0;
    fs = ls && yi == 0;
    return {xi[10:0], yi[10:0], hs, vs, en, m.stb, ls, fs};
  endfunction

  task automatic cmp(input string name, input logic [27:0] got, input logic [27:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s t=%0t got={x,y,hs,vs,en,stb,ls,fs}=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  // Reference models advance on the same edges as the DUTs.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ma = MRST; mb = MRST; mc = MRST;
    end else begin
      ma = step(CFG_A, ma, run_a);
      mb = step(CFG_B, mb, run_b);
      mc = step(CFG_C, mc, run_c);
    end
  end

  // Per-cycle comparison, sampled on the inactive edge.
  initial forever begin
    @(negedge clk);
    if (!done) begin
      cmp("model_a", {x_a, y_a, hs_a, vs_a, en_a, stb_a, ls_a, fs_a}, expect_out(CFG_A, ma));
      cmp("model_b", {x_b, y_b, hs_b, vs_b, en_b, stb_b, ls_b, fs_b}, expect_out(CFG_B, mb));
      cmp("model_c", {x_c, y_c, hs_c, vs_c, en_c, stb_c, ls_c, fs_c}, expect_out(CFG_C, mc));
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("fcnt_a", int'(fc_a), ma.fcnt);
      check("fcnt_b", int'(fc_b), mb.fcnt);
      check("fcnt_c", int'(fc_c), mc.fcnt);
`endif
    end
  end

  // Random run pattern for instance B, biased towards running.
  initial begin
    while (!done) begin
      repeat ($urandom_range(1, 60)) @(negedge clk);
      run_b = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int n, gaps, en_cnt, hmask, vmask, lastx, lasty, fcount, stbs;
    repeat (3) @(negedge clk);
    check("rst_x", x_a, 0);
    check("rst_hsync_a", hs_a, 1);
    check("rst_hsync_b", hs_b, 0);
    check("rst_stb", stb_a, 0);
    #2 rst = 1'b0;

    // CLK_DIV=1: frame_start on the first edge after release.
    @(negedge clk);
    check("first_fs", fs_a, 1);
    check("first_x", x_a, 0);

    // One full small frame: period, visible count and sync positions.
    n = 0; en_cnt = 0; hmask = 0; vmask = 0;
    do begin
      if (en_a) en_cnt++;
      if (!hs_a) hmask |= (1 << x_a);
      if (!vs_a) vmask |= (1 << y_a);
      @(negedge clk);
      n++;
    end while (!fs_a && n < 200);
    check("fs_period", n, 48);
    check("en_count", en_cnt, 12);
    check("hsync_low_x", hmask, 'h60);
    check("vsync_low_y", vmask, 'h10);

    // Drop run at (2,1): frame completes through (7,5), then IDLE.
    n = 0;
    while (!(x_a == 2 && y_a == 1) && n < 100) begin @(negedge clk); n++; end
    check("reach_2_1", int'(n < 100), 1);
    run_a = 1'b0;
    n = 0; lastx = 2; lasty = 1;
    do begin
      @(negedge clk);
      n++;
      if (stb_a) begin lastx = x_a; lasty = y_a; end
    end while (stb_a && n < 200);
    check("stop_last_x", lastx, 7);
    check("stop_last_y", lasty, 5);
    check("idle_x", x_a, 0);
    check("idle_y", y_a, 0);
    check("idle_en", en_a, 0);
    stbs = 0;
    repeat (20) begin @(negedge clk); if (stb_a) stbs++; end
    check("idle_no_stb", stbs, 0);

    // Restart, then stop/reassert inside the frame: no gap, 48-clk spacing.
    run_a = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!fs_a && n < 20);
    check("restart_fs", fs_a, 1);
    n = 0; gaps = 0;
    do begin
      @(negedge clk);
      n++;
      if (x_a == 0 && y_a == 1) run_a = 1'b0;
      if (x_a == 0 && y_a == 3) run_a = 1'b1;
      if (!stb_a) gaps++;
    end while (!fs_a && n < 200);
    check("reassert_period", n, 48);
    check("reassert_gaps", gaps, 0);

    // Asynchronous reset mid-line at (3,2).
    n = 0;
    while (!(x_a == 3 && y_a == 2) && n < 100) begin @(negedge clk); n++; end
    check("reach_3_2", int'(n < 100), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_x", x_a, 0);
    check("arst_y", y_a, 0);
    check("arst_en", en_a, 0);
    check("arst_hs", hs_a, 1);
    check("arst_vs", vs_a, 1);
    check("arst_pulses", {stb_a, ls_a, fs_a}, 0);
    check("arst_hs_b", hs_b, 0);
    check("arst_vs_b", vs_b, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_fs", fs_a, 1);
    check("post_rst_xy", {x_a, y_a}, 0);

    // Count frame starts, then stop and confirm the counter holds in IDLE.
    fcount = 1; n = 0;
    while (fcount < 4 && n < 300) begin
      @(negedge clk); n++;
      if (fs_a) fcount++;
    end
    check("four_fs", fcount, 4);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fcnt_after_4", int'(fc_a), 3);
`endif
    run_a = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (stb_a && n < 100);
    check("stop_to_idle", int'(n < 100), 1);
    repeat (20) @(negedge clk);
    check("idle_stb_a", stb_a, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fcnt_idle_hold", int'(fc_a), 3);
`endif

    // Default raster, CLK_DIV=4: strobe period and line wrap at 799.
    n = 0;
    while (!stb_c && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!stb_c && n < 20);
      check("c_stb_period", n, 4);
    end
    n = 0;
    while (!(x_c == 799 && stb_c) && n < 4000) begin @(negedge clk); n++; end
    check("c_reach_799", int'(n < 4000), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!stb_c && n < 20);
    check("c_wrap_x", x_c, 0);
    check("c_wrap_y", y_c, 1);
    check("c_wrap_ls", ls_c, 1);

    // Let the random-run instance keep going for a while.
    repeat (1500) @(negedge clk);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
